// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - 640x480@60 VGA timing constants, RGB444 colour type and letterbox defaults
package vga_pkg;
  localparam int H_VISIBLE = 640;
  localparam int H_FRONT   = 16;
  localparam int H_SYNC    = 96;
  localparam int H_TOTAL   = 800;
  localparam int V_VISIBLE = 480;
  localparam int V_FRONT   = 10;
  localparam int V_SYNC    = 2;
  localparam int V_TOTAL   = 525;
  localparam int CNT_W     = 10;

  typedef logic [11:0] rgb444_t;

  localparam int      LB_WIDTH    = 320;
  localparam int      LB_HEIGHT   = 180;
  localparam int      LB_V_OFFSET = 60;
  localparam rgb444_t LB_BORDER   = 12'h000;
endpackage

// File: rtl/vga_timing.sv
// rtl/vga_timing.sv - VGA h/v counters with visible/sync decode and a frame-line compare
// o_frame_line is high on the last pixel before the counters load (0, FRAME_LINE).
module vga_timing
  import vga_pkg::*;
#(
  parameter int FRAME_LINE = 0
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_pix_stb,
  output logic [CNT_W-1:0] o_h,
  output logic [CNT_W-1:0] o_v,
  output logic             o_visible,
  output logic             o_hsync_n,
  output logic             o_vsync_n,
  output logic             o_frame_line
);
  localparam logic [CNT_W-1:0] H_LAST     = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST     = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_VIS      = CNT_W'(H_VISIBLE);
  localparam logic [CNT_W-1:0] V_VIS      = CNT_W'(V_VISIBLE);
  localparam logic [CNT_W-1:0] HS_START   = CNT_W'(H_VISIBLE + H_FRONT);
  localparam logic [CNT_W-1:0] HS_END     = CNT_W'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [CNT_W-1:0] VS_START   = CNT_W'(V_VISIBLE + V_FRONT);
  localparam logic [CNT_W-1:0] VS_END     = CNT_W'(V_VISIBLE + V_FRONT + V_SYNC);
  localparam logic [CNT_W-1:0] FRAME_PREV = CNT_W'((FRAME_LINE == 0) ? V_TOTAL - 1 : FRAME_LINE - 1);

  logic [CNT_W-1:0] r_h;
  logic [CNT_W-1:0] r_v;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_h <= '0;
      r_v <= '0;
    end else if (i_pix_stb) begin
      if (r_h == H_LAST) begin
        r_h <= '0;
        r_v <= (r_v == V_LAST) ? '0 : r_v + 1'b1;
      end else begin
        r_h <= r_h + 1'b1;
      end
    end
  end

  assign o_h          = r_h;
  assign o_v          = r_v;
  assign o_visible    = (r_h < H_VIS) && (r_v < V_VIS);
  assign o_hsync_n    = !((r_h >= HS_START) && (r_h < HS_END));
  assign o_vsync_n    = !((r_v >= VS_START) && (r_v < VS_END));
  assign o_frame_line = (r_h == H_LAST) && (r_v == FRAME_PREV);
endmodule

// File: rtl/vram_scanout.sv
// rtl/vram_scanout.sv - VRAM read side: 320x180 frame at 2x into a centred 640x360 letterbox on 640x480@60 VGA
// Define SCANOUT_BORDER_EN to fill visible pixels outside the letterbox with BORDER_COLOR.
module vram_scanout
  import vga_pkg::*;
#(
  parameter int                     VRAM_A_WIDTH  = 16,
  parameter int                     COLOR_WIDTH   = 12,
  parameter int                     SCREEN_WIDTH  = LB_WIDTH,
  parameter int                     SCREEN_HEIGHT = LB_HEIGHT,
  parameter int                     V_OFFSET      = LB_V_OFFSET,
  parameter logic [COLOR_WIDTH-1:0] BORDER_COLOR  = COLOR_WIDTH'(LB_BORDER)
) (
  input  logic                    CLK,
  input  logic                    rst,
  input  logic                    pix_stb,
  input  logic [COLOR_WIDTH-1:0]  i_vram_data,
  input  logic                    i_is_layer_drawing,
  output logic [VRAM_A_WIDTH-1:0] o_address_screen,
  output logic [COLOR_WIDTH-1:0]  o_color,
  output logic                    o_hs,
  output logic                    o_vs,
  output logic                    o_blank,
  output logic                    o_screenend,
  output logic                    o_overrun
);
  localparam logic [CNT_W-1:0] H_LAST  = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] LB_TOP  = CNT_W'(V_OFFSET);
  localparam logic [CNT_W-1:0] LB_BOT  = CNT_W'(V_OFFSET + 2 * SCREEN_HEIGHT);
  localparam logic [CNT_W-1:0] LB_PREV = CNT_W'((V_OFFSET == 0) ? V_TOTAL - 1 : V_OFFSET - 1);
`ifdef SCANOUT_BORDER_EN
  localparam logic [COLOR_WIDTH-1:0] FILL_COLOR = BORDER_COLOR;
`else
  localparam logic [COLOR_WIDTH-1:0] FILL_COLOR = BORDER_COLOR & {COLOR_WIDTH{1'b0}};
`endif

  // Row base address as a constant shift-add over the set bits of SCREEN_WIDTH.
  function automatic logic [VRAM_A_WIDTH-1:0] row_base(input logic [CNT_W-1:0] y);
    logic [VRAM_A_WIDTH-1:0] acc;
    acc = '0;
    for (int i = 0; i < 32; i++) begin
      if (SCREEN_WIDTH[i]) acc = acc + (VRAM_A_WIDTH'(y) << i);
    end
    return acc;
  endfunction

  logic [CNT_W-1:0]        w_h;
  logic [CNT_W-1:0]        w_v;
  logic                    w_visible;
  logic                    w_hsync_n;
  logic                    w_vsync_n;
  logic                    w_frame_end;
  logic                    w_in_lb;
  logic                    w_lb_enter;
  logic [CNT_W-1:0]        w_row;
  logic [VRAM_A_WIDTH-1:0] w_addr;

  vga_timing #(
    .FRAME_LINE (V_OFFSET + 2 * SCREEN_HEIGHT)
  ) u_timing (
    .i_clk        (CLK),
    .i_rst        (rst),
    .i_pix_stb    (pix_stb),
    .o_h          (w_h),
    .o_v          (w_v),
    .o_visible    (w_visible),
    .o_hsync_n    (w_hsync_n),
    .o_vsync_n    (w_vsync_n),
    .o_frame_line (w_frame_end)
  );

  assign w_in_lb    = w_visible && (w_v >= LB_TOP) && (w_v < LB_BOT);
  assign w_lb_enter = (w_h == H_LAST) && (w_v == LB_PREV);
  assign w_row      = (w_v - LB_TOP) >> 1;
  assign w_addr     = row_base(w_row) + VRAM_A_WIDTH'(w_h >> 1);

  logic r_s0_lb;
  logic r_s0_vis;
  logic r_s0_hs;
  logic r_s0_vs;

  // Stage 0 registers the address and pixel flags; stage 1 muxes the returned data.
  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      o_address_screen <= '0;
      r_s0_lb          <= 1'b0;
      r_s0_vis         <= 1'b0;
      r_s0_hs          <= 1'b1;
      r_s0_vs          <= 1'b1;
      o_color          <= '0;
      o_hs             <= 1'b1;
      o_vs             <= 1'b1;
      o_blank          <= 1'b1;
      o_screenend      <= 1'b0;
      o_overrun        <= 1'b0;
    end else if (pix_stb) begin
      o_address_screen <= w_in_lb ? w_addr : '0;
      r_s0_lb          <= w_in_lb;
      r_s0_vis         <= w_visible;
      r_s0_hs          <= w_hsync_n;
      r_s0_vs          <= w_vsync_n;
      if (!r_s0_vis)    o_color <= '0;
      else if (r_s0_lb) o_color <= i_vram_data;
      else              o_color <= FILL_COLOR;
      o_hs             <= r_s0_hs;
      o_vs             <= r_s0_vs;
      o_blank          <= !r_s0_vis;
      o_screenend      <= w_frame_end;
      if (w_lb_enter && i_is_layer_drawing) o_overrun <= 1'b1;
    end
  end
endmodule
